square_wave_meter: RTL
======================

// Module: square_wave_meter
//
// PURPOSE
//   Measures an external square wave on an input pin: period and high time, counted in clk cycles.
//   It is the receive-side counterpart to the pin-toggling divider outputs.
//   Used for on-board loopback checks (divider pin -> meter pin) and for measuring external clocks.
//   Results drive status/debug logic in the top level.
//
// PARAMETERS
//   CNT_W        24         width of the cycle counter, period and high_time outputs
//   TIMEOUT_CYC  12_000_000 cycles without a rising edge before the input is declared stalled; must be < 2**CNT_W
//
// PORTS
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous reset, active low
//   sig_in     in   1      asynchronous square-wave input, from a pin
//   period     out  CNT_W  clk cycles between the last two rising edges
//   high_time  out  CNT_W  clk cycles from the last rising edge to the following falling edge
//   valid      out  1      one-cycle strobe: period/high_time just updated
//   stalled    out  1      level: no rising edge for TIMEOUT_CYC cycles
//
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - period=0, high_time=0, valid=0, stalled=0.
//     - sync flops=0, cnt=0, state=IDLE.
//   Input path:
//     - 2-FF synchronizer, then a previous-value flop.
//     - rise = s2 & ~prev; fall = ~s2 & prev.
//   Latency: sig_in 0->1 captured at clk edge k; rise true between edges k+1 and k+2; outputs registered at edge k+2.
//   FSM, 2 states:
//     - IDLE:
//       - cnt held at 0, valid=0.
//       - On rise: cnt<=1, stalled<=0, go to MEASURE.
//       - No valid on this first edge.
//     - MEASURE:
//       - cnt<=cnt+1 each cycle.
//       - On fall: hi_cap<=cnt (internal capture).
//       - On rise: period<=cnt, high_time<=hi_cap, valid<=1, cnt<=1.
//       - On cnt==TIMEOUT_CYC-1 with no rise: stalled<=1, cnt<=0, go to IDLE; period/high_time keep their last values.
//   Arithmetic and precedence:
//     - For sig_in with period P cycles and high time H cycles, steady state gives period==P and high_time==H.
//     - cnt never wraps; the timeout fires before overflow.
//     - A rise in the same cycle as the timeout compare wins: a normal update, no stall.
//     - rise and fall cannot coincide (single synchronized bit).
//   Other rules:
//     - valid is exactly one cycle wide; it is never asserted two cycles in a row.
//     - sig_in stuck high: fall never occurs, so high_time is stale until the next full cycle. The timeout still fires.
//     - Reset mid-measurement: all state is cleared. The first rise after release gives no valid; the second gives valid.
//
// STRUCTURE
//   - meter_pkg: state enum (ST_IDLE, ST_MEASURE) and the default CNT_W/TIMEOUT_CYC constants.
//   - Sub-module sync_edge_detect (clk, rst_n, d -> level, rise, fall): synchronizer plus edge flops, reusable for other pins.
//   - This module holds the FSM, cnt, hi_cap and output registers.
//
// TESTING
//   - Reset with sig_in=0, then square wave P=1500/H=750 for 4 periods:
//     - No valid on the 1st rise.
//     - valid pulses on rises 2-4 with period=1500, high_time=750.
//   - Duty change, P=12000, H=3000 (TIMEOUT_CYC reduced to 50_000): period=12000, high_time=3000 from the 2nd update.
//   - Stall: TIMEOUT_CYC=1000, hold sig_in low after a 500-cycle wave.
//     - stalled=1 exactly 1000 cycles after the last detected rise; period stays 500.
//     - The next two rises clear stalled, then give valid with the new period.
//   - Boundary: a rise lands in the cycle cnt==TIMEOUT_CYC-1 -> valid=1, period=TIMEOUT_CYC-1, stalled stays 0.
//   - Minimum wave, P=4, H=2: valid every 4 cycles, period=4, high_time=2, never two consecutive valid cycles.
//   - Async reset asserted mid-period: outputs go to 0 immediately.
//     - After release, the 1st rise gives no valid; the 2nd gives a correct period.

Source files
------------

// File: rtl/meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : meter_pkg
//  Description : Shared types and default constants for the square-wave
//                meter: FSM state encoding and default counter sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package meter_pkg;

    // Default counter width and stall timeout (in clk cycles).
    localparam int c_CNT_W_DEFAULT       = 24;
    localparam int c_TIMEOUT_CYC_DEFAULT = 12_000_000;

    // IDLE: waiting for the first rising edge after reset or after a stall.
    // MEASURE: counting clk cycles since the most recent rising edge.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meter_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_detect
//  Description : Two-flop synchronizer for an asynchronous pin followed by a
//                previous-value flop, producing single-cycle rise/fall pulses.
//  Ports       : clk   in  1  system clock
//                rst_n in  1  asynchronous reset, active low
//                d     in  1  asynchronous input pin
//                level out 1  synchronized level
//                rise  out 1  one-cycle pulse on a synchronized 0->1
//                fall  out 1  one-cycle pulse on a synchronized 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    // Both edges derive from the same synchronized bit, so they are
    // mutually exclusive by construction.
    assign level = s2_q;
    assign rise  = s2_q & ~prev_q;
    assign fall  = ~s2_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/square_wave_meter.sv
`default_nettype none
// ============================================================================
//  Module      : square_wave_meter
//  Description : Measures an external square wave in clk cycles: the period
//                between the last two rising edges and the high time from a
//                rising edge to the following falling edge. Flags a stall
//                when no rising edge arrives for TIMEOUT_CYC cycles.
//  Ports       : clk       in  1      system clock
//                rst_n     in  1      asynchronous reset, active low
//                sig_in    in  1      asynchronous square-wave input pin
//                period    out CNT_W  cycles between the last two rises
//                high_time out CNT_W  cycles from last rise to next fall
//                valid     out 1      one-cycle strobe: results updated
//                stalled   out 1      level: no rise for TIMEOUT_CYC cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module square_wave_meter
    import meter_pkg::*;
#(
    parameter int CNT_W       = c_CNT_W_DEFAULT,
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stalled
);

    // Last count value reached before declaring a stall. TIMEOUT_CYC is
    // below 2**CNT_W, so the counter never wraps.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic w_level_unused;
    logic w_rise;
    logic w_fall;

    sync_edge_detect u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .level (w_level_unused),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             stalled_q, stalled_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_cap_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_cap_q    <= hi_cap_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            stalled_q   <= stalled_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_cap_d    = hi_cap_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        stalled_d   = stalled_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // First edge only arms the counter; no full period yet.
                if (w_rise) begin
                    cnt_d     = CNT_W'(1);
                    stalled_d = 1'b0;
                    state_d   = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                // cnt equals the number of cycles since the last rise, so
                // its value on the fall/rise cycle is the measurement.
                cnt_d = cnt_q + CNT_W'(1);
                if (w_fall) begin
                    hi_cap_d = cnt_q;
                end
                // A rise on the timeout cycle takes priority over the stall.
                if (w_rise) begin
                    period_d    = cnt_q;
                    high_time_d = hi_cap_q;
                    valid_d     = 1'b1;
                    cnt_d       = CNT_W'(1);
                end else if (cnt_q == c_CNT_LAST) begin
                    stalled_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign stalled   = stalled_q;

endmodule
`default_nettype wire
